// File: rtl/arq_tx_ctrl.sv
// -----------------------------------------------------------------------------
// arq_tx_ctrl
// Transmit-side ARQ controller for the SECDED FIFO link. It accepts one word
// from a producer and writes it into the FIFO. The first attempt can carry an
// injected error. It then issues the read that launches the FIFO check and
// waits for the registered ack/nack. On nack or timeout it retransmits the
// word clean, up to MAX_RETRY times, and then reports failure.
//
// Parameters
//   DATA_WIDTH  word width; matches the FIFO data width
//   MAX_RETRY   retransmissions allowed after the first attempt (>= 1)
//   TIMEOUT     WAIT cycles without ack/nack before a retransmit (>= 2)
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   in_valid/in_ready       producer handshake
//   in_data, in_err_mode    word and first-attempt injection mode
//                           (00 none, 01 single-bit, 10 double-bit)
//   wr_en, wr_data          FIFO write strobe and data
//   rd_en                   FIFO read strobe (launches the check)
//   err_mode                FIFO injection mode for the current attempt
//   ack, nack               FIFO registered check result
//   done, fail              one-cycle pulses: delivered / retries exhausted
//   retry_cnt               retransmissions used for the current or last word
//   busy                    high in every state except IDLE
// -----------------------------------------------------------------------------
module arq_tx_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_RETRY  = 3,
   parameter int TIMEOUT    = 8
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             in_valid,
   input  logic [DATA_WIDTH-1:0]            in_data,
   input  logic [1:0]                       in_err_mode,
   output logic                             in_ready,
   output logic                             wr_en,
   output logic [DATA_WIDTH-1:0]            wr_data,
   output logic                             rd_en,
   output logic [1:0]                       err_mode,
   input  logic                             ack,
   input  logic                             nack,
   output logic                             done,
   output logic                             fail,
   output logic [$clog2(MAX_RETRY+1)-1:0]   retry_cnt,
   output logic                             busy
);

   localparam int RW = $clog2(MAX_RETRY + 1);
   localparam int TW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_WAIT
   } state_t;

   state_t                r_state;
   logic [TW-1:0]         r_timer;
   logic                  r_in_ready;
   logic                  r_wr_en;
   logic [DATA_WIDTH-1:0] r_wr_data;
   logic                  r_rd_en;
   logic [1:0]            r_err_mode;
   logic                  r_done;
   logic                  r_fail;
   logic [RW-1:0]         r_retry_cnt;
   logic                  r_busy;

   // A retry is forced by nack (nack beats a simultaneous ack) or by the
   // last WAIT cycle passing with no ack at all.
   logic w_retry_req;
   logic w_retry_left;

   assign w_retry_req  = nack || (!ack && (r_timer == TW'(TIMEOUT - 1)));
   assign w_retry_left = (r_retry_cnt != RW'(MAX_RETRY));

   // NOTE: every register here, including the latched word in r_wr_data, is
   //       cleared by the async reset; a reset mid-transfer must drop the word
   //       and leave no stale data on the FIFO write bus.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_timer     <= '0;
         r_in_ready  <= 1'b0;
         r_wr_en     <= 1'b0;
         r_wr_data   <= '0;
         r_rd_en     <= 1'b0;
         r_err_mode  <= 2'b00;
         r_done      <= 1'b0;
         r_fail      <= 1'b0;
         r_retry_cnt <= '0;
         r_busy      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout; the defaults below make
         //       the strobes single-cycle pulses and are overridden later in
         //       the same block where a state asks for a pulse.
         r_wr_en <= 1'b0;
         r_rd_en <= 1'b0;
         r_done  <= 1'b0;
         r_fail  <= 1'b0;

         case (r_state)
            S_IDLE: begin
               r_in_ready <= 1'b1;
               r_busy     <= 1'b0;
               r_err_mode <= 2'b00;
               if (in_valid && r_in_ready) begin
                  // r_wr_data doubles as the latched copy for retransmits.
                  r_wr_data   <= in_data;
                  r_err_mode  <= in_err_mode;
                  r_retry_cnt <= '0;
                  r_in_ready  <= 1'b0;
                  r_busy      <= 1'b1;
                  r_wr_en     <= 1'b1;
                  r_state     <= S_WRITE;
               end
            end

            S_WRITE: begin
               r_rd_en <= 1'b1;
               r_state <= S_READ;
            end

            S_READ: begin
               r_timer <= '0;
               r_state <= S_WAIT;
            end

            S_WAIT: begin
               r_timer <= r_timer + 1'b1;
               if (w_retry_req) begin
                  if (w_retry_left) begin
                     // Retransmissions always go out clean.
                     r_retry_cnt <= r_retry_cnt + 1'b1;
                     r_err_mode  <= 2'b00;
                     r_wr_en     <= 1'b1;
                     r_state     <= S_WRITE;
                  end else begin
                     r_fail     <= 1'b1;
                     r_in_ready <= 1'b1;
                     r_busy     <= 1'b0;
                     r_err_mode <= 2'b00;
                     r_state    <= S_IDLE;
                  end
               end else if (ack) begin
                  r_done     <= 1'b1;
                  r_in_ready <= 1'b1;
                  r_busy     <= 1'b0;
                  r_err_mode <= 2'b00;
                  r_state    <= S_IDLE;
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign wr_en     = r_wr_en;
   assign wr_data   = r_wr_data;
   assign rd_en     = r_rd_en;
   assign err_mode  = r_err_mode;
   assign done      = r_done;
   assign fail      = r_fail;
   assign retry_cnt = r_retry_cnt;
   assign busy      = r_busy;

endmodule

// File: tb/tb_arq_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_arq_tx_ctrl
// Scoreboard bench for arq_tx_ctrl. The stimulus process pushes the expected
// wr_en pulses and the closing done/fail event for each transfer. A monitor
// pops and compares whenever the DUT shows wr_en, done or fail. A small FIFO
// stub answers each rd_en with ack/nack two cycles later.
// -----------------------------------------------------------------------------
module tb_arq_tx_ctrl;

   localparam int DW  = 8;
   localparam int MR  = 3;
   localparam int TO  = 8;
   localparam int RW  = $clog2(MR + 1);

   localparam logic [1:0] K_W = 2'd0;
   localparam logic [1:0] K_D = 2'd1;
   localparam logic [1:0] K_F = 2'd2;

   typedef enum logic [1:0] {
      STUB_FIFO,    // ack, except nack for a double-bit injection
      STUB_NACK,    // always nack
      STUB_SILENT,  // never answers
      STUB_BOTH     // ack+nack together on one chosen read, else FIFO
   } stub_t;

   typedef struct {
      logic [1:0]    kind;
      logic [DW-1:0] data;
      logic [1:0]    mode;
      int            gap;   // required cycles since previous wr_en, 0 = any
      int            rc;
   } exp_t;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic [1:0]    in_err_mode;
   logic          in_ready;
   logic          wr_en;
   logic [DW-1:0] wr_data;
   logic          rd_en;
   logic [1:0]    err_mode;
   logic          ack;
   logic          nack;
   logic          done;
   logic          fail;
   logic [RW-1:0] retry_cnt;
   logic          busy;

   exp_t  sb[$];
   int    n_checks = 0;
   int    n_pass   = 0;
   stub_t stub_mode = STUB_FIFO;
   int    both_at   = -1;
   int    rd_total  = 0;

   arq_tx_ctrl #(
      .DATA_WIDTH (DW),
      .MAX_RETRY  (MR),
      .TIMEOUT    (TO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_err_mode (in_err_mode),
      .in_ready    (in_ready),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .rd_en       (rd_en),
      .err_mode    (err_mode),
      .ack         (ack),
      .nack        (nack),
      .done        (done),
      .fail        (fail),
      .retry_cnt   (retry_cnt),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual == expected) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   // FIFO stub: result appears on ack/nack in the second cycle after rd_en.
   logic [1:0] p1 = 2'b00;
   logic [1:0] p2 = 2'b00;
   always @(negedge clk) begin
      logic [1:0] r;
      if (!rst_n) begin
         p1 = 2'b00; p2 = 2'b00; ack = 1'b0; nack = 1'b0;
      end else begin
         ack  = p2[1];
         nack = p2[0];
         p2   = p1;
         r    = 2'b00;
         if (rd_en) begin
            case (stub_mode)
               STUB_NACK:   r = 2'b01;
               STUB_SILENT: r = 2'b00;
               STUB_BOTH:   r = (rd_total == both_at) ? 2'b11
                                : ((err_mode == 2'b10) ? 2'b01 : 2'b10);
               default:     r = (err_mode == 2'b10) ? 2'b01 : 2'b10;
            endcase
            rd_total++;
         end
         p1 = r;
      end
   end

   // Monitor: compares every DUT event against the head of the scoreboard.
   int   cyc     = 0;
   int   last_wr = 0;
   logic prev_wr = 1'b0;
   always @(posedge clk) begin
      exp_t e;
      #1;
      cyc++;
      if (!rst_n) begin
         prev_wr = 1'b0;
      end else begin
         if (wr_en) begin
            if (sb.size() == 0) begin
               check("unexpected_wr_en", 1, 0);
            end else begin
               e = sb.pop_front();
               check("wr_evt_kind", int'(K_W), int'(e.kind));
               check("wr_data", int'(wr_data), int'(e.data));
               check("wr_err_mode", int'(err_mode), int'(e.mode));
               if (e.gap != 0) check("wr_gap", cyc - last_wr, e.gap);
            end
            last_wr = cyc;
         end
         if (rd_en) check("rd_after_wr", int'(prev_wr), 1);
         if (done || fail) begin
            if (sb.size() == 0) begin
               check("unexpected_done_fail", 1, 0);
            end else begin
               e = sb.pop_front();
               check("end_evt_kind", done ? int'(K_D) : int'(K_F), int'(e.kind));
               check("end_both_pulses", int'(done && fail), 0);
               check("end_retry_cnt", int'(retry_cnt), e.rc);
               check("end_in_ready", int'(in_ready), 1);
            end
         end
         prev_wr = wr_en;
      end
   end

   task automatic push_w(input logic [DW-1:0] d, input logic [1:0] m, input int gap);
      exp_t e;
      e.kind = K_W; e.data = d; e.mode = m; e.gap = gap; e.rc = 0;
      sb.push_back(e);
   endtask

   task automatic push_end(input logic [1:0] k, input int rc);
      exp_t e;
      e.kind = k; e.data = '0; e.mode = 2'b00; e.gap = 0; e.rc = rc;
      sb.push_back(e);
   endtask

   // Called at a negedge; returns at the negedge after the accept edge.
   task automatic send(input logic [DW-1:0] d, input logic [1:0] m);
      int n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_before_send", int'(in_ready), 1);
      in_valid    = 1'b1;
      in_data     = d;
      in_err_mode = m;
      @(negedge clk);
      in_valid    = 1'b0;
      in_data     = 8'hEE;
      in_err_mode = 2'b11;
   endtask

   task automatic finish_txn(input string tag, input int rc);
      int n = 0;
      while ((busy || sb.size() != 0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_sb_drained"}, sb.size(), 0);
      check({tag, "_not_busy"}, int'(busy), 0);
      repeat (3) @(negedge clk);
      check({tag, "_retry_cnt_hold"}, int'(retry_cnt), rc);
      check({tag, "_in_ready"}, int'(in_ready), 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"},  int'(in_ready),  0);
      check({tag, "_wr_en"},     int'(wr_en),     0);
      check({tag, "_wr_data"},   int'(wr_data),   0);
      check({tag, "_rd_en"},     int'(rd_en),     0);
      check({tag, "_err_mode"},  int'(err_mode),  0);
      check({tag, "_done"},      int'(done),      0);
      check({tag, "_fail"},      int'(fail),      0);
      check({tag, "_retry_cnt"}, int'(retry_cnt), 0);
      check({tag, "_busy"},      int'(busy),      0);
   endtask

   initial begin
      rst_n       = 1'b1;
      in_valid    = 1'b0;
      in_data     = '0;
      in_err_mode = 2'b00;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("por");
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("in_ready_low_before_edge", int'(in_ready), 0);
      @(negedge clk);
      check("in_ready_after_release", int'(in_ready), 1);

      // Clean word.
      stub_mode = STUB_FIFO;
      push_w(8'hA5, 2'b00, 0); push_end(K_D, 0);
      send(8'hA5, 2'b00);
      finish_txn("a5", 0);

      // Corrected single-bit injection still acks.
      push_w(8'h3C, 2'b01, 0); push_end(K_D, 0);
      send(8'h3C, 2'b01);
      finish_txn("3c", 0);

      // Double-bit injection nacks; retry goes out clean, 4 cycles later.
      push_w(8'h5A, 2'b10, 0); push_w(8'h5A, 2'b00, 4); push_end(K_D, 1);
      send(8'h5A, 2'b10);
      finish_txn("5a", 1);

      // Persistent nack: 4 attempts then fail.
      stub_mode = STUB_NACK;
      push_w(8'hC3, 2'b10, 0);
      for (int i = 0; i < MR; i++) push_w(8'hC3, 2'b00, 4);
      push_end(K_F, MR);
      send(8'hC3, 2'b10);
      finish_txn("nack", MR);

      // Silent FIFO: each retry after write + read + TIMEOUT wait cycles.
      stub_mode = STUB_SILENT;
      push_w(8'h96, 2'b00, 0);
      for (int i = 0; i < MR; i++) push_w(8'h96, 2'b00, TO + 2);
      push_end(K_F, MR);
      send(8'h96, 2'b00);
      finish_txn("timeout", MR);

      // ack and nack together on the first read count as nack.
      both_at   = rd_total;
      stub_mode = STUB_BOTH;
      push_w(8'h4B, 2'b00, 0); push_w(8'h4B, 2'b00, 4); push_end(K_D, 1);
      send(8'h4B, 2'b00);
      finish_txn("both", 1);

      // Reset during WAIT: everything clears at once, no done/fail follows.
      stub_mode = STUB_FIFO;
      push_w(8'h77, 2'b01, 0);
      send(8'h77, 2'b01);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1 check_reset_outputs("mid_rst");
      check("mid_rst_sb_drained", sb.size(), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("in_ready_after_mid_rst", int'(in_ready), 1);
      repeat (6) @(negedge clk);
      check("no_pulse_after_mid_rst", int'(done || fail || busy), 0);

      push_w(8'h11, 2'b00, 0); push_end(K_D, 0);
      send(8'h11, 2'b00);
      finish_txn("11", 0);

      check("final_sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/arq_tx_ctrl.md
# arq_tx_ctrl

Transmit-side ARQ controller for the SECDED FIFO link. It accepts one word at a time from an upstream producer and writes it into the FIFO with an optional error-injection mode. It then issues the read that launches the FIFO's check and waits for the registered ack/nack. On nack or timeout it retransmits the word clean, up to a retry limit. It sits between the producer and the FIFO's write/read/err_mode/ack/nack pins.

## Interface
- DATA_WIDTH, 8, word width; matches the FIFO data width.
- MAX_RETRY, 3, maximum retransmissions after the first attempt.
- TIMEOUT, 8, number of WAIT cycles without ack/nack before a retransmit is forced; minimum 2.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  producer has a word.
- in_data  in  DATA_WIDTH  word to send.
- in_err_mode  in  2  injection mode for the first attempt: 00 none, 01 single-bit, 10 double-bit.
- in_ready  out  1  controller is idle and accepts a word.
- wr_en  out  1  FIFO write strobe.
- wr_data  out  DATA_WIDTH  FIFO write data.
- rd_en  out  1  FIFO read strobe.
- err_mode  out  2  FIFO injection mode.
- ack  in  1  FIFO registered ack.
- nack  in  1  FIFO registered nack.
- done  out  1  one-cycle pulse: word delivered.
- fail  out  1  one-cycle pulse: retry limit exhausted, word dropped.
- retry_cnt  out  $clog2(MAX_RETRY+1)  retransmissions used for the current or last word.
- busy  out  1  high in any state except IDLE.

## Operation
- All outputs are registered.
- Reset values: in_ready=0, wr_en=0, wr_data=0, rd_en=0, err_mode=00, done=0, fail=0, retry_cnt=0, busy=0. State is IDLE.
- in_ready rises the first cycle after reset release.
- States: IDLE, WRITE, READ, WAIT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_data and in_err_mode, clear retry_cnt, clear in_ready, go to WRITE.
- WRITE:
  - wr_en=1 for exactly one cycle, with wr_data=latched word.
  - err_mode=latched mode on attempt 0 and 00 on every retry.
  - Go to READ.
- READ: rd_en=1 for exactly one cycle, then go to WAIT with the timer cleared.
- err_mode holds its value through WRITE, READ and WAIT, and returns to 00 in IDLE.
- WAIT: the timer increments each cycle. At each edge:
  - nack=1, or timer==TIMEOUT-1 with no ack: if retry_cnt==MAX_RETRY, pulse fail and go to IDLE; otherwise increment retry_cnt and go to WRITE.
  - ack=1 and nack=0: pulse done and go to IDLE.
  - If ack and nack are both high, nack wins.
- ack/nack are ignored outside WAIT.
- in_valid is ignored while busy. The producer must hold the word until in_ready is seen.
- retry_cnt saturates at MAX_RETRY and holds after done/fail until the next accept.

## Timing
- Accept at edge 0 → wr_en high in cycle 1 → rd_en high in cycle 2 → WAIT from cycle 3.
- The FIFO delivers ack/nack two cycles after rd_en, so the nominal response is sampled at the edge ending cycle 4. done/fail is high in cycle 5 and in_ready is high in cycle 5.
- A retransmit's wr_en is high in the cycle after the nack edge.
- Minimum spacing between wr_en pulses of consecutive attempts is 4 cycles.
- Reset asserted mid-operation: all outputs go to reset values immediately (asynchronous). The latched word is discarded, no done/fail pulse is produced, and the controller returns to IDLE.

## Test plan
- 0xA5 with err_mode 00, FIFO clean → one wr_en with wr_data=A5 and err_mode 00, one rd_en, done pulse, retry_cnt=0, fail never high.
- 0x3C with err_mode 01 (corrected single-bit error) → ack on the first attempt, done, retry_cnt=0.
- 0x5A with err_mode 10 → nack; second wr_en carries 5A with err_mode 00; ack; done; retry_cnt=1.
- ack/nack stub forcing nack, MAX_RETRY=3 → exactly 4 wr_en pulses (err_mode 10,00,00,00), fail pulse, done never high, retry_cnt=3.
- ack and nack both tied low, TIMEOUT=8 → each retransmit wr_en follows 8 WAIT cycles; fail after the 4th timeout. Separately, ack and nack asserted together are treated as nack (retry_cnt increments).
- rst_n pulled low during WAIT of a 0x77 transfer → all outputs 0 the same cycle, no done/fail. After release, in_ready=1 and a new word 0x11 completes normally.
